// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit. The CPU control
// unit imports the same op encodings so both sides agree on the 2-bit opcode.
//   op_e    : MULT / MULTU / DIV / DIVU encodings
//   state_e : unit FSM states
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_e;

  // Opcode bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/result bundle between the control unit (master) and muldiv_unit
// (slave).
//   start, op, a, b               : request, sampled only while the unit idles
//   busy, done, div_zero, hi, lo  : status and registered HI/LO results
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Purely combinational radix-2 iteration for muldiv_unit; all state lives in
// the caller.
//   i_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   i_prod : multiply: {upper partial product, remaining multiplier bits}
//            divide:   lower half is dividend / quotient being built
//   i_rem  : divide partial remainder (one spare bit for the borrow)
//   i_opd  : multiplicand or divisor magnitude
//   o_prod, o_rem : register values after this step
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH:0]     i_rem,
  input  logic [WIDTH-1:0]   i_opd,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH:0]     o_rem
);

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole register right by one. The
  // carry out of the add becomes the new MSB.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_mul_sum  = {1'b0, i_prod[2*WIDTH-1:WIDTH]}
                    + (i_prod[0] ? {1'b0, i_opd} : '0);
  assign w_mul_prod = {w_mul_sum, i_prod[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder and trial-subtract
  // the divisor; a borrow means restore (keep the shifted value, quotient 0).
  logic [WIDTH+1:0] w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_borrow;

  assign w_div_shift  = {i_rem, i_prod[WIDTH-1]};
  assign w_div_diff   = w_div_shift - {2'b00, i_opd};
  assign w_div_borrow = w_div_diff[WIDTH+1];

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_prod = w_mul_prod;
    o_rem  = i_rem;
    if (i_div) begin
      o_prod = {i_prod[2*WIDTH-1:WIDTH], i_prod[WIDTH-2:0], ~w_div_borrow};
      o_rem  = w_div_borrow ? w_div_shift[WIDTH:0] : w_div_diff[WIDTH:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative signed/unsigned multiply and divide with integrated HI/LO result
// registers. One radix-2 step per cycle; WIDTH+1 edges from start to done,
// one edge for a divide by zero. HI/LO update only on the done edge.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : muldiv_unit_if slave (start/op/a/b in; busy/done/div_zero/hi/lo out)
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             r_state, w_state_nxt;
  op_e                r_op, w_op_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
  logic [WIDTH:0]     r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_opd, w_opd_nxt;
  logic               r_neg_q, w_neg_q_nxt;   // product / quotient sign
  logic               r_neg_r, w_neg_r_nxt;   // remainder follows dividend sign
  logic               r_dz, w_dz_nxt;
  logic               r_busy, r_done, w_done_nxt, r_div_zero, w_div_zero_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt, r_lo, w_lo_nxt;

  // Operand conditioning at issue: magnitudes of signed operands. -MIN wraps
  // to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  logic             w_in_div, w_in_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_in_div    = op_is_div(bus.op);
  assign w_in_signed = op_is_signed(bus.op);
  assign w_a_neg     = w_in_signed & bus.a[WIDTH-1];
  assign w_b_neg     = w_in_signed & bus.b[WIDTH-1];
  assign w_abs_a     = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b     = w_b_neg ? -bus.b : bus.b;

  logic               w_run_div;
  logic [2*WIDTH-1:0] w_step_prod;
  logic [WIDTH:0]     w_step_rem;

  assign w_run_div = op_is_div(r_op);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_div  (w_run_div),
    .i_prod (r_prod),
    .i_rem  (r_rem),
    .i_opd  (r_opd),
    .o_prod (w_step_prod),
    .o_rem  (w_step_rem)
  );

  // Sign fix-up of the magnitude results. MIN / -1 needs no special case:
  // quotient magnitude 2^(WIDTH-1) with positive sign is the MIN bit pattern.
  logic [2*WIDTH-1:0] w_prod_res;
  logic [WIDTH-1:0]   w_quo_mag, w_rem_mag, w_quo_res, w_rem_res;

  assign w_prod_res = r_neg_q ? -r_prod : r_prod;
  assign w_quo_mag  = r_prod[WIDTH-1:0];
  assign w_rem_mag  = r_rem[WIDTH-1:0];
  assign w_quo_res  = r_neg_q ? -w_quo_mag : w_quo_mag;
  assign w_rem_res  = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_cnt_nxt      = r_cnt;
    w_prod_nxt     = r_prod;
    w_rem_nxt      = r_rem;
    w_opd_nxt      = r_opd;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_dz_nxt       = r_dz;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_done_nxt     = 1'b0;
    w_div_zero_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_op_nxt    = bus.op;
          w_cnt_nxt   = CW'(WIDTH);
          w_rem_nxt   = '0;
          w_neg_q_nxt = w_a_neg ^ w_b_neg;
          w_neg_r_nxt = w_a_neg;
          w_dz_nxt    = 1'b0;
          w_state_nxt = RUN;
          if (w_in_div) begin
            // Dividend sits in the low half; quotient bits replace it.
            w_prod_nxt = {{WIDTH{1'b0}}, w_abs_a};
            w_opd_nxt  = w_abs_b;
            if (bus.b == '0) begin
              w_dz_nxt    = 1'b1;
              w_state_nxt = FINISH;
            end
          end else begin
            // Multiplier sits in the low half and is consumed LSB first.
            w_prod_nxt = {{WIDTH{1'b0}}, w_abs_b};
            w_opd_nxt  = w_abs_a;
          end
        end
      end

      RUN: begin
        w_prod_nxt = w_step_prod;
        w_rem_nxt  = w_step_rem;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = FINISH;
        end
      end

      FINISH: begin
        w_state_nxt    = IDLE;
        w_done_nxt     = 1'b1;
        w_div_zero_nxt = r_dz;
        if (!r_dz) begin
          if (w_run_div) begin
            w_hi_nxt = w_rem_res;
            w_lo_nxt = w_quo_res;
          end else begin
            {w_hi_nxt, w_lo_nxt} = w_prod_res;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= OP_MULT;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_opd      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prod     <= w_prod_nxt;
      r_rem      <= w_rem_nxt;
      r_opd      <= w_opd_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      r_dz       <= w_dz_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
      r_div_zero <= w_div_zero_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with a start/done handshake and integrated HI/LO result registers. It is the successor to the separate fixed-width multiplier, divider, HI/LO muxes and HI/LO registers in the multicycle CPU datapath. The control unit issues one of four operations and stalls on `busy`. HI/LO update atomically when `done` pulses.

## Interface
- `WIDTH`, 32: operand and result width; any integer ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `op`  in  2  operation:
  - 00 MULT (signed)
  - 01 MULTU
  - 10 DIV (signed)
  - 11 DIVU
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  pulses with `done` when a DIV/DIVU had `b == 0`.
- `hi`  out  WIDTH  MULT: upper product half; DIV: remainder.
- `lo`  out  WIDTH  MULT: lower product half; DIV: quotient.

## Operation
- FSM states: IDLE, RUN, FINISH.
- **IDLE**, `start` = 1, normal case:
  - latch `op`.
  - For signed ops, latch |a| and |b| as unsigned WIDTH-bit values (|MIN| = 2^(WIDTH-1)) and record result signs.
  - Clear the accumulator/remainder; set iteration counter to WIDTH.
  - Go to RUN.
- **IDLE**, `start` = 1, DIV/DIVU with `b == 0`: go directly to FINISH with the zero flag set.
- **RUN**: one radix-2 step per cycle; counter decrements; when the counter reaches 1, go to FINISH.
  - Multiply: shift-add on a 2·WIDTH product register.
  - Divide: restoring shift-subtract; quotient bits shift into the dividend register.
- **FINISH**: apply the result to HI/LO, then go to IDLE.
  - Multiply: negate the 2·WIDTH product if the signs differ.
  - Signed divide: quotient negated if sign(a) ≠ sign(b); remainder takes sign(a).
  - MIN / −1 yields `lo` = MIN, `hi` = 0. This falls out of the magnitude path; no special case is needed.
  - Normal case: write `hi`/`lo`, `done` ← 1, `div_zero` ← 0.
  - Zero-divisor case: `hi`/`lo` unchanged, `done` ← 1, `div_zero` ← 1.
- `start` while `busy` = 1 is ignored, with no queueing.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Output `hi`/`lo` change only on the `done` edge. They are never partially updated mid-operation.
- Widths:
  - product register is 2·WIDTH.
  - remainder register is WIDTH+1 (borrow bit).
  - counter is $clog2(WIDTH)+1 bits.

## Timing
- Reset (asynchronous, `reset` = 0), immediately:
  - state IDLE.
  - `busy`, `done`, `div_zero` = 0.
  - `hi`, `lo` = 0.
  - counter and internal registers = 0.
  - Reset mid-RUN discards the operation with no `done`.
- Start accepted at edge E0:
  - `busy` = 1 from E0 through E(WIDTH+1); it falls at E(WIDTH+1).
  - `done` is high for exactly the cycle after E(WIDTH+1).
  - Total latency: WIDTH+1 edges.
- Divide-by-zero: start at E0, FINISH at E1, `done` = `div_zero` = 1 in the cycle after E1 (latency 1 edge).
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`).
  - the FSM state type (IDLE, RUN, FINISH).
  - The CPU control unit imports the same encodings.
- One combinational sub-module, `muldiv_step`, parametrised by WIDTH. From the current product/remainder registers and the mode bit, it computes the next multiply step or next divide step; the FSM owns all state.

## Test plan
1. WIDTH=32, MULT a=0xFFFFFFFD (−3), b=7 → `done` 33 edges after start; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `div_zero`=0.
2. MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then MULTU 0×0x1234 → `hi`=`lo`=0.
3. DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2 → `lo`=3, `hi`=1. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
4. After test 3, DIVU a=5, b=0 → `done` and `div_zero` high one edge after start, one cycle wide; `hi`=0, `lo`=0x80000000 unchanged.
5. MULT 6×7 started, then `start` pulsed with DIVU 9/3 at cycle 5 → ignored; result `lo`=42. Issue DIVU 9/3 in the `done` cycle → accepted; `lo`=3, `hi`=0 after a further 33 edges.
6. Repeat test 1 with `reset` asserted at cycle 10 of RUN → `busy`, `done`, `hi`, `lo` = 0 immediately, no `done` afterwards. Repeat the full suite at WIDTH=8, e.g. MULT 0x80×0x80 → `hi`=0x40, `lo`=0x00.
